// File: rtl/ysyx_23060332_sram.sv
// AXI-lite style 64-bit SRAM model with fixed access latency.
// Independent read and write FSMs share one word array.
module ysyx_23060332_sram #(
    parameter int          DEPTH = 4096,
    parameter logic [31:0] BASE  = 32'h8000_0000,
    parameter int          LAT   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        arvalid,
    output logic        arready,
    input  logic [31:0] araddr,
    output logic        rvalid,
    input  logic        rready,
    output logic [63:0] rdata,
    output logic [1:0]  rresp,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] awaddr,
    input  logic        wvalid,
    output logic        wready,
    input  logic [63:0] wdata,
    input  logic [7:0]  wstrb,
    output logic        bvalid,
    input  logic        bready,
    output logic [1:0]  bresp
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(LAT - 1);
    localparam logic [32:0]   SPAN     = 33'(DEPTH) << 3;

    localparam logic [1:0] RIDLE = 2'd0, RWAIT = 2'd1, RRESP = 2'd2;
    localparam logic [1:0] WIDLE = 2'd0, WWAIT = 2'd1, WRESP = 2'd2;
    localparam logic [1:0] RESP_OK = 2'b00, RESP_ERR = 2'b10;

    logic [63:0] mem [DEPTH];

    logic [1:0]    rstate_q, rstate_d;
    logic [CW-1:0] rcnt_q, rcnt_d;
    logic [31:0]   araddr_q, araddr_d;
    logic [63:0]   rdata_q, rdata_d;
    logic [1:0]    rresp_q, rresp_d;

    logic [1:0]    wstate_q, wstate_d;
    logic [CW-1:0] wcnt_q, wcnt_d;
    logic          aw_held_q, aw_held_d;
    logic          w_held_q, w_held_d;
    logic [31:0]   awaddr_q, awaddr_d;
    logic [63:0]   wdata_q, wdata_d;
    logic [7:0]    wstrb_q, wstrb_d;
    logic [1:0]    bresp_q, bresp_d;

    logic [31:0]   r_off, w_off;
    logic          r_ok, w_ok;
    logic [AW-1:0] r_idx, w_idx;
    logic          aw_hs, w_hs, commit;

    // Addresses below BASE wrap to large offsets, so one unsigned compare covers both bounds.
    assign r_off = araddr_q - BASE;
    assign w_off = awaddr_q - BASE;
    assign r_ok  = {1'b0, r_off} < SPAN;
    assign w_ok  = {1'b0, w_off} < SPAN;
    assign r_idx = AW'(r_off >> 3);
    assign w_idx = AW'(w_off >> 3);

    assign arready = (rstate_q == RIDLE);
    assign rvalid  = (rstate_q == RRESP);
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign awready = (wstate_q == WIDLE) && !aw_held_q;
    assign wready  = (wstate_q == WIDLE) && !w_held_q;
    assign bvalid  = (wstate_q == WRESP);
    assign bresp   = bresp_q;
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;

    always_comb begin
        rstate_d = rstate_q;
        rcnt_d   = rcnt_q;
        araddr_d = araddr_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        case (rstate_q)
            RIDLE: if (arvalid) begin
                araddr_d = araddr;
                rcnt_d   = CNT_INIT;
                rstate_d = RWAIT;
            end
            RWAIT: if (rcnt_q == '0) begin
                rdata_d  = r_ok ? mem[r_idx] : 64'd0;
                rresp_d  = r_ok ? RESP_OK : RESP_ERR;
                rstate_d = RRESP;
            end else begin
                rcnt_d = rcnt_q - CW'(1);
            end
            RRESP: if (rready) rstate_d = RIDLE;
            default: rstate_d = RIDLE;
        endcase
    end

    always_comb begin
        wstate_d  = wstate_q;
        wcnt_d    = wcnt_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bresp_d   = bresp_q;
        commit    = 1'b0;
        case (wstate_q)
            WIDLE: begin
                if (aw_hs) begin
                    awaddr_d  = awaddr;
                    aw_held_d = 1'b1;
                end
                if (w_hs) begin
                    wdata_d  = wdata;
                    wstrb_d  = wstrb;
                    w_held_d = 1'b1;
                end
                if ((aw_held_q || aw_hs) && (w_held_q || w_hs)) begin
                    wcnt_d   = CNT_INIT;
                    wstate_d = WWAIT;
                end
            end
            WWAIT: if (wcnt_q == '0) begin
                commit    = w_ok;
                bresp_d   = w_ok ? RESP_OK : RESP_ERR;
                aw_held_d = 1'b0;
                w_held_d  = 1'b0;
                wstate_d  = WRESP;
            end else begin
                wcnt_d = wcnt_q - CW'(1);
            end
            WRESP: if (bready) wstate_d = WIDLE;
            default: wstate_d = WIDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rstate_q  <= RIDLE;
            rcnt_q    <= '0;
            araddr_q  <= '0;
            rdata_q   <= '0;
            rresp_q   <= '0;
            wstate_q  <= WIDLE;
            wcnt_q    <= '0;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bresp_q   <= '0;
        end else begin
            rstate_q  <= rstate_d;
            rcnt_q    <= rcnt_d;
            araddr_q  <= araddr_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            wstate_q  <= wstate_d;
            wcnt_q    <= wcnt_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bresp_q   <= bresp_d;
        end
    end

    // Array is never reset; a read latching this same edge sees the pre-write word.
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int i = 0; i < 8; i++) begin
                if (wstrb_q[i]) mem[w_idx][i*8 +: 8] <= wdata_q[i*8 +: 8];
            end
        end
    end

endmodule

// File: doc/ysyx_23060332_sram.md
YSYX_23060332_SRAM -- requirements
Module: ysyx_23060332_sram

Interface
REQ-001 SHALL have parameter DEPTH, default 4096, meaning the number of 64-bit words in the array (power of two).
REQ-002 SHALL have parameter BASE, default 32'h8000_0000, meaning the byte address of word 0.
REQ-003 SHALL have parameter LAT, default 2, meaning the access-wait cycles per transaction (LAT >= 1).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have read-address ports: arvalid in 1, arready out 1, araddr in 32.
REQ-007 SHALL have read-data ports: rvalid out 1, rready in 1, rdata out 64, rresp out 2.
REQ-008 SHALL have write-address ports: awvalid in 1, awready out 1, awaddr in 32.
REQ-009 SHALL have write-data ports: wvalid in 1, wready out 1, wdata in 64, wstrb in 8.
REQ-010 SHALL have write-response ports: bvalid out 1, bready in 1, bresp out 2.

Function
REQ-011 SHALL complete a transfer on any channel only in a cycle where valid and ready are both high.
REQ-012 SHALL run the read FSM as RIDLE -> RWAIT -> RRESP -> RIDLE.
REQ-013 SHALL drive arready=1 only in RIDLE, capture araddr on the AR handshake, and enter RWAIT with a counter loaded to LAT-1.
REQ-014 SHALL decrement the RWAIT counter each cycle; at zero it SHALL latch rdata and rresp, then enter RRESP.
REQ-015 SHALL hold rvalid=1 with rdata and rresp stable in RRESP until rready, then return to RIDLE; minimum AR-to-R latency is LAT+1 cycles.
REQ-016 SHALL run the write FSM as WIDLE -> WWAIT -> WRESP -> WIDLE.
REQ-017 SHALL in WIDLE accept AW and W independently, in the same or different cycles; awready drops once AW is captured and wready drops once W is captured.
REQ-018 SHALL enter WWAIT with the counter loaded to LAT-1 in the cycle after both AW and W are held.
REQ-019 SHALL at WWAIT zero update only the bytes i with wstrb[i]=1, then enter WRESP.
REQ-020 SHALL hold bvalid=1 and bresp stable in WRESP until bready, then return to WIDLE.
REQ-021 SHALL index the array by (addr-BASE)>>3 and ignore address bits [2:0].
REQ-022 SHALL treat an address outside [BASE, BASE+8*DEPTH) as an error: rresp/bresp=2'b10, rdata=0, array unchanged; otherwise resp=2'b00.
REQ-023 SHALL keep the read and write FSMs independent, so both may be in flight at once.
REQ-024 SHALL return the pre-write data to a read that samples in the same cycle the write commits to the same word.
REQ-025 SHALL, when wstrb=8'h00 and the address is in range, leave the array unchanged and return bresp=2'b00.
REQ-026 SHALL never drop a response while its ready is low, for any number of stall cycles.

Reset
REQ-027 SHALL, while rst=0, force both FSMs to idle, clear the counters and captured flags, and drive arready=1, awready=1, wready=1, rvalid=0, bvalid=0, rdata=0, rresp=0, bresp=0.
REQ-028 SHALL, on reset mid-transaction, abandon any uncommitted write and leave array contents unspecified only for a write committing in the reset cycle.
REQ-029 SHALL not reset array contents.

Verification
REQ-030 SHALL pass this case: write 0x8000_0008 data 0x1122334455667788 wstrb 0xFF, then read the same address -> rdata=0x1122334455667788, rresp=0; AR-to-rvalid = LAT+1 cycles.
REQ-031 SHALL pass this case: W presented 3 cycles before AW -> no commit until AW arrives; bvalid asserts LAT+1 cycles after the AW handshake.
REQ-032 SHALL pass this case: prior word 0xFFFF..FF, write 0 with wstrb 0x0F -> readback 0xFFFFFFFF00000000.
REQ-033 SHALL pass this case: read 0x7FFF_FFF8 and write 0x8000_8000 (DEPTH=4096) -> rresp=2'b10, rdata=0, bresp=2'b10, array unchanged.
REQ-034 SHALL pass this case: rready held low 5 cycles -> rvalid and rdata stable throughout, arready=0 until the handshake completes.
REQ-035 SHALL pass this case: rst pulsed low during WWAIT -> outputs match REQ-027; a subsequent read of that address returns the old data.
